// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared types and constants for the router control slice.
//               Provides the FSM state encoding, the invalid header address,
//               the soft-reset timeout length, the output port count and a
//               one-hot helper used to build FIFO write enables.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

  localparam int          NUM_PORTS      = 3;
  localparam logic [1:0]  ADDR_INVALID   = 2'b11;
  localparam int          TIMEOUT_CYCLES = 30;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  // One-hot write enable for a destination port; the invalid address maps
  // to no port at all.
  function automatic logic [NUM_PORTS-1:0] addr_onehot(input logic [1:0] addr);
    logic [NUM_PORTS-1:0] r;
    case (addr)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_if.sv
`default_nettype none
// ============================================================================
// Module      : router_if
// Description : Bundle of the router controller's handshake and status
//               signals.
//               slave  : controller view (source/FIFO/datapath status in,
//                        state strobes, write enables, busy, soft resets out)
//               master : environment view (the opposite directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface router_if;
  import router_pkg::*;

  // Source side
  logic                 pkt_valid;
  logic [1:0]           din;
  // Output FIFO status and destination reads
  logic                 fifo_full_0, fifo_full_1, fifo_full_2;
  logic                 fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic                 read_enb_0, read_enb_1, read_enb_2;
  // Datapath status
  logic                 parity_done;
  logic                 low_pkt_valid;
  // Controller outputs
  logic                 detect_addr, lfd_state, ld_state, laf_state;
  logic                 full_state, rst_int_reg;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] write_enb;
  logic                 busy;
  logic                 soft_reset_0, soft_reset_1, soft_reset_2;

  modport slave (
    input  pkt_valid, din,
    input  fifo_full_0, fifo_full_1, fifo_full_2,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  parity_done, low_pkt_valid,
    output detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output fifo_full, write_enb, busy,
    output soft_reset_0, soft_reset_1, soft_reset_2
  );

  modport master (
    output pkt_valid, din,
    output fifo_full_0, fifo_full_1, fifo_full_2,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output read_enb_0, read_enb_1, read_enb_2,
    output parity_done, low_pkt_valid,
    input  detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  fifo_full, write_enb, busy,
    input  soft_reset_0, soft_reset_1, soft_reset_2
  );

endinterface
`default_nettype wire

// File: rtl/router_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : router_timeout_ctr
// Description : Per-port idle watchdog. Counts cycles in which the FIFO holds
//               data but nobody reads it; on the TIMEOUT_CYCLES-th such
//               cycle it emits a one-cycle soft reset and starts over.
// Ports       : clk, rst (sync, active-low)
//               fifo_empty_i - FIFO empty flag
//               read_enb_i   - destination read strobe
//               soft_reset_o - registered one-cycle flush pulse
// Revision    : 1.0 - initial release
// ============================================================================
module router_timeout_ctr
  import router_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic fifo_empty_i,
  input  logic read_enb_i,
  output logic soft_reset_o
);

  localparam logic [4:0] LAST_COUNT = 5'(TIMEOUT_CYCLES - 1);

  logic [4:0] count_q;
  logic       soft_reset_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q      <= '0;
      soft_reset_q <= 1'b0;
    end else if (fifo_empty_i || read_enb_i) begin
      count_q      <= '0;
      soft_reset_q <= 1'b0;
    end else if (count_q == LAST_COUNT) begin
      // This idle cycle is the last one tolerated: flush and restart.
      count_q      <= '0;
      soft_reset_q <= 1'b1;
    end else begin
      count_q      <= count_q + 5'd1;
      soft_reset_q <= 1'b0;
    end
  end

  assign soft_reset_o = soft_reset_q;

endmodule
`default_nettype wire

// File: rtl/router_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : router_ctrl
// Description : Packet router control FSM. Decodes the header address,
//               sequences loading of header/payload/parity into the selected
//               output FIFO, stalls the source while the FIFO is busy or full,
//               and optionally flushes a FIFO whose reader has gone idle.
// Ports       : clk, rst (sync, active-low)
//               bus - router_if.slave (see router_if for signal list)
// Config      : ROUTER_SOFT_RST_EN - when defined, per-port idle timeout
//               counters drive soft_reset_0/1/2 and abort the current packet;
//               when undefined the soft resets are tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module router_ctrl
  import router_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  router_if.slave  bus
);

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  logic       detect_addr_q, lfd_state_q, ld_state_q, laf_state_q;
  logic       full_state_q, rst_int_reg_q, busy_q;
  logic [2:0] write_enb_q;

  // Port-indexed views; padded to four entries so the 2-bit address can
  // index them without going out of range.
  logic [2:0] empty_v, full_v, read_v, soft_v;
  logic [3:0] empty_x, full_x, soft_x;

  assign empty_v = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign full_v  = {bus.fifo_full_2,  bus.fifo_full_1,  bus.fifo_full_0};
  assign read_v  = {bus.read_enb_2,   bus.read_enb_1,   bus.read_enb_0};
  assign empty_x = {1'b0, empty_v};
  assign full_x  = {1'b0, full_v};
  assign soft_x  = {1'b0, soft_v};

`ifdef ROUTER_SOFT_RST_EN
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_timeout
    router_timeout_ctr u_timeout (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty_i (empty_v[p]),
      .read_enb_i   (read_v[p]),
      .soft_reset_o (soft_v[p])
    );
  end
`else
  assign soft_v = '0;
  logic unused_read;
  assign unused_read = ^read_v;
`endif

  logic fifo_full_sel;
  assign fifo_full_sel = full_x[addr_q];

  // Next-state decode
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (soft_x[addr_q]) begin
      // The FIFO of the packet in flight was flushed: abandon it.
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (bus.pkt_valid && (bus.din != ADDR_INVALID)) begin
            addr_d  = bus.din;
            state_d = empty_x[bus.din] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full_sel)      state_d = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full_sel) state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (bus.parity_done)        state_d = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
          else                        state_d = LOAD_DATA;
        end
        LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          if (empty_x[addr_q]) state_d = LOAD_FIRST_DATA;
        end
        default:            state_d = DECODE_ADDRESS;
      endcase
    end
  end

  // State register; Moore outputs are registered from the next state so
  // they line up exactly with state_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= DECODE_ADDRESS;
      addr_q        <= 2'd0;
      detect_addr_q <= 1'b1;
      lfd_state_q   <= 1'b0;
      ld_state_q    <= 1'b0;
      laf_state_q   <= 1'b0;
      full_state_q  <= 1'b0;
      rst_int_reg_q <= 1'b0;
      busy_q        <= 1'b0;
      write_enb_q   <= 3'b000;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      detect_addr_q <= (state_d == DECODE_ADDRESS);
      lfd_state_q   <= (state_d == LOAD_FIRST_DATA);
      ld_state_q    <= (state_d == LOAD_DATA);
      laf_state_q   <= (state_d == LOAD_AFTER_FULL);
      full_state_q  <= (state_d == FIFO_FULL_STATE);
      rst_int_reg_q <= (state_d == CHECK_PARITY_ERROR);
      busy_q        <= !((state_d == DECODE_ADDRESS) || (state_d == LOAD_DATA));
      write_enb_q   <= ((state_d == LOAD_FIRST_DATA) || (state_d == LOAD_DATA) ||
                        (state_d == LOAD_AFTER_FULL) || (state_d == LOAD_PARITY))
                       ? addr_onehot(addr_d) : 3'b000;
    end
  end

  assign bus.detect_addr  = detect_addr_q;
  assign bus.lfd_state    = lfd_state_q;
  assign bus.ld_state     = ld_state_q;
  assign bus.laf_state    = laf_state_q;
  assign bus.full_state   = full_state_q;
  assign bus.rst_int_reg  = rst_int_reg_q;
  assign bus.busy         = busy_q;
  assign bus.write_enb    = write_enb_q;
  assign bus.fifo_full    = fifo_full_sel;
  assign bus.soft_reset_0 = soft_v[0];
  assign bus.soft_reset_1 = soft_v[1];
  assign bus.soft_reset_2 = soft_v[2];

endmodule
`default_nettype wire

// File: tb/tb_router_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_ctrl
// Description : Directed self-checking bench for router_ctrl. Inputs change
//               1 time unit after the rising edge and outputs are compared
//               at that point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_ctrl;

  // Strobe pattern {detect_addr, lfd, ld, laf, full, rst_int_reg}
  localparam logic [5:0] S_DA  = 6'b100000;
  localparam logic [5:0] S_LFD = 6'b010000;
  localparam logic [5:0] S_LD  = 6'b001000;
  localparam logic [5:0] S_LAF = 6'b000100;
  localparam logic [5:0] S_FF  = 6'b000010;
  localparam logic [5:0] S_LP  = 6'b000000;
  localparam logic [5:0] S_CPE = 6'b000001;
  localparam logic [5:0] S_WTE = 6'b000000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  router_if bus ();

  router_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] strb;
  assign strb = {bus.detect_addr, bus.lfd_state, bus.ld_state,
                 bus.laf_state, bus.full_state, bus.rst_int_reg};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [5:0] s, input logic b, input logic [2:0] we);
    check_eq({tag, "_strobes"}, 32'(strb), 32'(s));
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'(b));
    check_eq({tag, "_we"}, 32'(bus.write_enb), 32'(we));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.pkt_valid = 1'b0;
    bus.din = 2'b00;
    bus.fifo_full_0 = 1'b0; bus.fifo_full_1 = 1'b0; bus.fifo_full_2 = 1'b0;
    bus.fifo_empty_0 = 1'b1; bus.fifo_empty_1 = 1'b1; bus.fifo_empty_2 = 1'b1;
    bus.read_enb_0 = 1'b0; bus.read_enb_1 = 1'b0; bus.read_enb_2 = 1'b0;
    bus.parity_done = 1'b0;
    bus.low_pkt_valid = 1'b0;
    tick();
    tick();
    expect_state("reset", S_DA, 1'b0, 3'b000);
    check_eq("reset_soft0", 32'(bus.soft_reset_0), 32'd0);
    rst = 1'b1;

    // Packet to port 1, then end of packet through parity check
    bus.pkt_valid = 1'b1; bus.din = 2'b01;
    tick(); expect_state("p1_lfd", S_LFD, 1'b1, 3'b010);
    tick(); expect_state("p1_ld",  S_LD,  1'b0, 3'b010);
    check_eq("p1_ffull_lo", 32'(bus.fifo_full), 32'd0);
    bus.fifo_full_0 = 1'b1;
    #1 check_eq("p1_ffull_other", 32'(bus.fifo_full), 32'd0);
    bus.fifo_full_0 = 1'b0; bus.fifo_full_1 = 1'b1;
    #1 check_eq("p1_ffull_sel", 32'(bus.fifo_full), 32'd1);
    bus.fifo_full_1 = 1'b0;
    bus.pkt_valid = 1'b0;
    tick(); expect_state("p1_lp",  S_LP,  1'b1, 3'b010);
    tick(); expect_state("p1_cpe", S_CPE, 1'b1, 3'b000);
    tick(); expect_state("p1_da",  S_DA,  1'b0, 3'b000);

    // Invalid address holds in decode
    bus.pkt_valid = 1'b1; bus.din = 2'b11;
    tick(); expect_state("inv_1", S_DA, 1'b0, 3'b000);
    tick(); expect_state("inv_2", S_DA, 1'b0, 3'b000);

    // Port 2 not empty: wait five cycles, then load
    bus.din = 2'b10; bus.fifo_empty_2 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(); expect_state($sformatf("wte_%0d", i), S_WTE, 1'b1, 3'b000);
    end
    bus.fifo_empty_2 = 1'b1;
    tick(); expect_state("p2_lfd", S_LFD, 1'b1, 3'b100);
    tick(); expect_state("p2_ld",  S_LD,  1'b0, 3'b100);
    bus.pkt_valid = 1'b0;
    tick(); expect_state("p2_lp",  S_LP,  1'b1, 3'b100);
    bus.fifo_full_2 = 1'b1;
    tick(); expect_state("p2_cpe", S_CPE, 1'b1, 3'b000);
    tick(); expect_state("p2_ff",  S_FF,  1'b1, 3'b000);
    bus.fifo_full_2 = 1'b0; bus.parity_done = 1'b1;
    tick(); expect_state("p2_laf", S_LAF, 1'b1, 3'b100);
    tick(); expect_state("p2_da",  S_DA,  1'b0, 3'b000);
    bus.parity_done = 1'b0;

    // Port 0 with FIFO-full stalls
    bus.pkt_valid = 1'b1; bus.din = 2'b00;
    tick(); expect_state("p0_lfd", S_LFD, 1'b1, 3'b001);
    tick(); expect_state("p0_ld",  S_LD,  1'b0, 3'b001);
    bus.fifo_full_0 = 1'b1;
    tick(); expect_state("p0_ff1", S_FF,  1'b1, 3'b000);
    tick(); expect_state("p0_ff2", S_FF,  1'b1, 3'b000);
    bus.fifo_full_0 = 1'b0;
    tick(); expect_state("p0_laf1", S_LAF, 1'b1, 3'b001);
    tick(); expect_state("p0_ld2",  S_LD,  1'b0, 3'b001);
    bus.fifo_full_0 = 1'b1;
    tick(); expect_state("p0_ff3", S_FF,  1'b1, 3'b000);
    bus.fifo_full_0 = 1'b0;
    tick(); expect_state("p0_laf2", S_LAF, 1'b1, 3'b001);
    bus.low_pkt_valid = 1'b1; bus.pkt_valid = 1'b0;
    tick(); expect_state("p0_lp",  S_LP,  1'b1, 3'b001);
    bus.low_pkt_valid = 1'b0;
    tick(); expect_state("p0_cpe", S_CPE, 1'b1, 3'b000);
    tick(); expect_state("p0_da",  S_DA,  1'b0, 3'b000);

    // Reset in the middle of a packet
    bus.pkt_valid = 1'b1; bus.din = 2'b01;
    tick(); tick(); expect_state("mid_ld", S_LD, 1'b0, 3'b010);
    rst = 1'b0;
    tick(); expect_state("mid_rst", S_DA, 1'b0, 3'b000);
    rst = 1'b1;
    bus.din = 2'b00;

    // Idle-reader timeout on port 0 while loading a packet to it
    tick(); tick(); expect_state("to_ld", S_LD, 1'b0, 3'b001);
    bus.fifo_empty_0 = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
`ifdef ROUTER_SOFT_RST_EN
      check_eq($sformatf("to_soft_%0d", k), 32'(bus.soft_reset_0), 32'(k == 30));
`else
      check_eq($sformatf("to_soft_%0d", k), 32'(bus.soft_reset_0), 32'd0);
`endif
    end
`ifdef ROUTER_SOFT_RST_EN
    expect_state("to_after", S_DA, 1'b0, 3'b000);
`else
    expect_state("to_after", S_LD, 1'b0, 3'b001);
`endif
    bus.pkt_valid = 1'b0;

    // A read on cycle 20 restarts the count: no pulse within 40 cycles
    for (int k = 1; k <= 40; k++) begin
      bus.read_enb_0 = (k == 1) || (k == 20);
      tick();
      check_eq($sformatf("nopulse_%0d", k), 32'(bus.soft_reset_0), 32'd0);
    end
    bus.read_enb_0 = 1'b0;
    bus.fifo_empty_0 = 1'b1;
    tick();
    check_eq("end_soft1", 32'(bus.soft_reset_1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
